// File: rtl/bus_timer_responder.sv
// Memory-mapped 64-bit timer/compare responder: 32-byte window, zero-latency reads,
// byte-enabled writes, prescaled counting, sticky compare-match flag and IRQ.
module bus_timer_responder #(
   parameter logic [31:0] BASE_ADDR    = 32'hFF20_0500,
   parameter logic [31:0] PRESCALE_RST = 32'd0
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iReadEnable,
   input  logic        iWriteEnable,
   input  logic [3:0]  iByteEnable,
   input  logic [31:0] iAddress,
   input  logic [31:0] iWriteData,
   output logic [31:0] oReadData,
   output logic        oHit,
   output logic        oIRQ
);

   logic [63:0] r_time, r_cmp;
   logic [2:0]  r_ctrl;
   logic        r_pending;
   logic [31:0] r_prescale, r_pcnt, r_snap;

   logic [63:0] w_time_nxt, w_cmp_nxt, w_tnext;
   logic [2:0]  w_ctrl_nxt;
   logic        w_pend_nxt, w_tick, w_match, w_wr_any, w_rd;
   logic [31:0] w_prescale_nxt, w_pcnt_nxt, w_ctrl_wr;
   logic [2:0]  w_off;
   logic        w_unused_addr;

   function automatic logic [31:0] f_merge(input logic [31:0] i_old, input logic [31:0] i_new,
                                           input logic [3:0] i_be);
      logic [31:0] v;
      for (int n = 0; n < 4; n++) begin
         v[8*n +: 8] = i_be[n] ? i_new[8*n +: 8] : i_old[8*n +: 8];
      end
      return v;
   endfunction

   assign oHit          = (iAddress[31:5] == BASE_ADDR[31:5]);
   assign w_off         = iAddress[4:2];
   assign w_unused_addr = ^iAddress[1:0];
   assign w_wr_any      = iWriteEnable & oHit & (|iByteEnable);
   assign w_rd          = iReadEnable & oHit;
   assign w_ctrl_wr     = f_merge({29'd0, r_ctrl}, iWriteData, iByteEnable);
   assign oIRQ          = r_pending & r_ctrl[1];

   always_comb begin
      w_tick         = r_ctrl[0] & (r_pcnt == r_prescale);
      w_tnext        = r_time + 64'd1;
      w_match        = w_tick & (w_tnext == r_cmp);
      w_time_nxt     = r_time;
      w_cmp_nxt      = r_cmp;
      w_ctrl_nxt     = r_ctrl;
      w_prescale_nxt = r_prescale;
      w_pcnt_nxt     = r_pcnt;
      w_pend_nxt     = r_pending;

      if (r_ctrl[0]) w_pcnt_nxt = w_tick ? 32'd0 : r_pcnt + 32'd1;
      if (w_match && r_ctrl[2]) w_time_nxt = 64'd0;
      else if (w_tick)          w_time_nxt = w_tnext;

      // Bus writes override the tick update; untouched lanes keep their pre-edge value.
      if (w_wr_any) begin
         case (w_off)
            3'd0: w_time_nxt = {r_time[63:32], f_merge(r_time[31:0], iWriteData, iByteEnable)};
            3'd1: w_time_nxt = {f_merge(r_time[63:32], iWriteData, iByteEnable), r_time[31:0]};
            3'd2: w_cmp_nxt  = {r_cmp[63:32], f_merge(r_cmp[31:0], iWriteData, iByteEnable)};
            3'd3: w_cmp_nxt  = {f_merge(r_cmp[63:32], iWriteData, iByteEnable), r_cmp[31:0]};
            3'd4: w_ctrl_nxt = w_ctrl_wr[2:0];
            3'd5: if (iByteEnable[0] && iWriteData[0]) w_pend_nxt = 1'b0;
            3'd6: begin
               w_prescale_nxt = f_merge(r_prescale, iWriteData, iByteEnable);
               w_pcnt_nxt     = 32'd0;
            end
            default: ;
         endcase
      end

      if (w_match) w_pend_nxt = 1'b1;
   end

   always_comb begin
      oReadData = 32'd0;
      if (w_rd && !iRST) begin
         case (w_off)
            3'd0:    oReadData = r_time[31:0];
            3'd1:    oReadData = r_snap;
            3'd2:    oReadData = r_cmp[31:0];
            3'd3:    oReadData = r_cmp[63:32];
            3'd4:    oReadData = {29'd0, r_ctrl};
            3'd5:    oReadData = {31'd0, r_pending};
            3'd6:    oReadData = r_prescale;
            default: oReadData = 32'd0;
         endcase
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_time     <= 64'd0;
         r_cmp      <= 64'hFFFF_FFFF_FFFF_FFFF;
         r_ctrl     <= 3'd0;
         r_pending  <= 1'b0;
         r_prescale <= PRESCALE_RST;
         r_pcnt     <= 32'd0;
         r_snap     <= 32'd0;
      end else begin
         r_time     <= w_time_nxt;
         r_cmp      <= w_cmp_nxt;
         r_ctrl     <= w_ctrl_nxt;
         r_pending  <= w_pend_nxt;
         r_prescale <= w_prescale_nxt;
         r_pcnt     <= w_pcnt_nxt;
         // Upper half captured alongside a LO read so a following HI read cannot tear.
         if (w_rd && w_off == 3'd0) r_snap <= r_time[63:32];
      end
   end

endmodule
